deficit_rr_scheduler: RTL and testbench

//  Shares one output port between NUM_REQS per-requester FIFOs using deficit round robin.

---
 rtl/deficit_rr_scheduler.sv | 145 ++++++++++++++
 tb/tb_deficit_rr_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/deficit_rr_scheduler.sv
// deficit_rr_scheduler
//   Deficit round-robin arbiter that shares one output port between
//   NUM_REQS per-requester FIFOs. Each visit to a requester adds its
//   quantum to that requester's deficit counter. The requester is then
//   granted one packet per cycle for as long as the counter covers PSIZE.
//   The counter is carried over when the credit runs short. It is
//   forfeited when the queue runs empty.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   blk             downstream blocked; suppresses grants and freezes SERVE
//   reqs            per-requester request (FIFO non-empty)
//   input_quantums  flat quantums, requester i at [(i+1)*QWID-1:i*QWID]
//   gnt             one-hot grant, wired straight to the FIFO pops
//   busy            high whenever the scheduler is not IDLE
//   ptr             requester currently being selected or served

module deficit_rr_scheduler #(
    parameter int NUM_REQS = 4,
    parameter int QWID     = 8,
    parameter int PSIZE    = 8,
    parameter int DCWID    = QWID + 1,
    parameter int PWID     = $clog2(NUM_REQS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     blk,
    input  logic [NUM_REQS-1:0]      reqs,
    input  logic [NUM_REQS*QWID-1:0] input_quantums,
    output logic [NUM_REQS-1:0]      gnt,
    output logic                     busy,
    output logic [PWID-1:0]          ptr
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SELECT = 2'd1;
    localparam logic [1:0] SERVE  = 2'd2;

    localparam logic [DCWID-1:0] COST   = DCWID'(PSIZE);
    localparam logic [DCWID-1:0] DC_MAX = '1;
    localparam logic [PWID-1:0]  LAST   = PWID'(NUM_REQS - 1);

    logic [1:0]       state;
    logic [DCWID-1:0] dc [NUM_REQS];

    logic [QWID-1:0]  cur_quantum;
    logic [DCWID-1:0] cur_dc;
    logic             cur_req;
    logic [DCWID:0]   credit_sum;
    logic [DCWID-1:0] credit_sat;
    logic [PWID-1:0]  ptr_next;
    logic             eligible;
    logic             grant;

    // Pick out the quantum, deficit and request of the requester under the
    // pointer. The decode loop keeps the indexing safe for any NUM_REQS.
    always_comb begin
        cur_quantum = '0;
        cur_dc      = '0;
        cur_req     = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (ptr == PWID'(i)) begin
                cur_quantum = input_quantums[i*QWID +: QWID];
                cur_dc      = dc[i];
                cur_req     = reqs[i];
            end
        end
    end

    // Credit top-up saturates instead of wrapping. A wrap would turn a
    // large backlog of credit into almost none.
    always_comb begin
        credit_sum = {1'b0, cur_dc} + {{(DCWID + 1 - QWID){1'b0}}, cur_quantum};
        credit_sat = credit_sum[DCWID] ? DC_MAX : credit_sum[DCWID-1:0];
        ptr_next   = (ptr == LAST) ? '0 : ptr + 1'b1;
    end

    // Mealy grant: the pop fires in the same cycle as the decision.
    // Gating with rst makes an in-reset pop impossible even before the
    // state register has settled.
    always_comb begin
        eligible = cur_req && (cur_dc >= COST);
        grant    = (state == SERVE) && eligible && !blk && rst;
        gnt      = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (ptr == PWID'(i)) begin
                gnt[i] = grant;
            end
        end
        busy = (state != IDLE);
    end

    // Scheduler state machine.
    // SELECT tops up credit for the requester under the pointer, or skips
    // past an empty requester. SERVE spends that credit one packet at a
    // time. Backpressure freezes SERVE completely, so an exit that coincides
    // with blk rising is only taken after blk falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
            for (int i = 0; i < NUM_REQS; i++) begin
                dc[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (reqs != '0) begin
                        state <= SELECT;
                    end
                end
                SELECT: begin
                    if (reqs == '0) begin
                        state <= IDLE;
                    end else if (!cur_req) begin
                        dc[ptr] <= '0;
                        ptr     <= ptr_next;
                    end else begin
                        dc[ptr] <= credit_sat;
                        state   <= SERVE;
                    end
                end
                SERVE: begin
                    if (blk) begin
                        state <= SERVE;
                    end else if (eligible) begin
                        dc[ptr] <= cur_dc - COST;
                    end else if (!cur_req) begin
                        dc[ptr] <= '0;
                        ptr     <= ptr_next;
                        state   <= SELECT;
                    end else begin
                        ptr     <= ptr_next;
                        state   <= SELECT;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deficit_rr_scheduler.sv
// tb_deficit_rr_scheduler
//   Directed bench for deficit_rr_scheduler (NUM_REQS=4, QWID=8, PSIZE=8).
//   Each cycle is entered 1 time unit after the rising edge. Inputs are
//   driven at that point. Outputs are compared 1 time unit later.

module tb_deficit_rr_scheduler;

    logic        clk;
    logic        rst;
    logic        blk;
    logic [3:0]  reqs;
    logic [31:0] input_quantums;
    logic [3:0]  gnt;
    logic        busy;
    logic [1:0]  ptr;

    int checks;
    int errors;

    deficit_rr_scheduler #(
        .NUM_REQS(4),
        .QWID    (8),
        .PSIZE   (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .blk           (blk),
        .reqs          (reqs),
        .input_quantums(input_quantums),
        .gnt           (gnt),
        .busy          (busy),
        .ptr           (ptr)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a stuck design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 20000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic b);
        reqs = r;
        blk  = b;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] eg,
                               input logic eb, input logic [1:0] ep);
        #1;
        checks++;
        assert ({gnt, busy, ptr} === {eg, eb, ep})
        else begin
            errors++;
            $error("[TB] FAIL %s: observed gnt=%b busy=%b ptr=%0d, expected gnt=%b busy=%b ptr=%0d",
                   tag, gnt, busy, ptr, eg, eb, ep);
        end
    endtask

    task automatic stepCheck(input string tag, input logic [3:0] eg,
                             input logic eb, input logic [1:0] ep);
        tick();
        checkOutput(tag, eg, eb, ep);
    endtask

    task automatic doReset();
        rst = 1'b0;
        applyStimulus(4'b0000, 1'b0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int cnt [4];
        int total;

        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        blk            = 1'b0;
        reqs           = 4'b0000;
        input_quantums = '0;
        #2;

        // T1: reset holds everything quiet whatever the inputs do.
        $display("[TB] T1 reset");
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'($urandom_range(1, 15)), 1'($urandom));
            checkOutput("t1_in_reset", 4'b0000, 1'b0, 2'd0);
            tick();
        end
        applyStimulus(4'b0000, 1'b0);
        rst = 1'b1;
        checkOutput("t1_release", 4'b0000, 1'b0, 2'd0);
        stepCheck("t1_idle_hold", 4'b0000, 1'b0, 2'd0);
        applyStimulus(4'b0010, 1'b0);
        checkOutput("t1_idle_before_select", 4'b0000, 1'b0, 2'd0);
        stepCheck("t1_select_p0", 4'b0000, 1'b1, 2'd0);
        stepCheck("t1_select_p1", 4'b0000, 1'b1, 2'd1);

        // T2: a single backlogged requester with q0=16 gets two grants per
        // round. It then walks through the three idle requesters.
        $display("[TB] T2 single requester");
        doReset();
        input_quantums = {8'd0, 8'd0, 8'd0, 8'd16};
        applyStimulus(4'b0001, 1'b0);
        checkOutput("t2_c0_idle", 4'b0000, 1'b0, 2'd0);
        stepCheck("t2_c1_select", 4'b0000, 1'b1, 2'd0);
        stepCheck("t2_c2_gnt", 4'b0001, 1'b1, 2'd0);
        stepCheck("t2_c3_gnt", 4'b0001, 1'b1, 2'd0);
        stepCheck("t2_c4_exit", 4'b0000, 1'b1, 2'd0);
        stepCheck("t2_c5_p1", 4'b0000, 1'b1, 2'd1);
        stepCheck("t2_c6_p2", 4'b0000, 1'b1, 2'd2);
        stepCheck("t2_c7_p3", 4'b0000, 1'b1, 2'd3);
        stepCheck("t2_c8_p0", 4'b0000, 1'b1, 2'd0);
        stepCheck("t2_c9_gnt", 4'b0001, 1'b1, 2'd0);
        stepCheck("t2_c10_gnt", 4'b0001, 1'b1, 2'd0);
        rst = 1'b0;
        checkOutput("t2_async_reset_mid_serve", 4'b0000, 1'b0, 2'd0);

        // T3: carry-over. r0 keeps 4 credits after round 1 and gets two
        // grants in round 2.
        $display("[TB] T3 carry-over");
        doReset();
        input_quantums = {8'd0, 8'd0, 8'd8, 8'd12};
        applyStimulus(4'b0011, 1'b0);
        checkOutput("t3_c0_idle", 4'b0000, 1'b0, 2'd0);
        stepCheck("t3_c1_select", 4'b0000, 1'b1, 2'd0);
        stepCheck("t3_c2_gnt0", 4'b0001, 1'b1, 2'd0);
        stepCheck("t3_c3_short", 4'b0000, 1'b1, 2'd0);
        stepCheck("t3_c4_select1", 4'b0000, 1'b1, 2'd1);
        stepCheck("t3_c5_gnt1", 4'b0010, 1'b1, 2'd1);
        stepCheck("t3_c6_exit1", 4'b0000, 1'b1, 2'd1);
        stepCheck("t3_c7_p2", 4'b0000, 1'b1, 2'd2);
        stepCheck("t3_c8_p3", 4'b0000, 1'b1, 2'd3);
        stepCheck("t3_c9_select0", 4'b0000, 1'b1, 2'd0);
        stepCheck("t3_c10_gnt0", 4'b0001, 1'b1, 2'd0);
        stepCheck("t3_c11_gnt0", 4'b0001, 1'b1, 2'd0);
        stepCheck("t3_c12_exit0", 4'b0000, 1'b1, 2'd0);
        stepCheck("t3_c13_select1", 4'b0000, 1'b1, 2'd1);
        stepCheck("t3_c14_gnt1", 4'b0010, 1'b1, 2'd1);
        stepCheck("t3_c15_exit1", 4'b0000, 1'b1, 2'd1);

        // T4: the queue empties after one grant, so its 12 leftover credits
        // are lost. A later visit with quantum 0 must then yield no grant.
        $display("[TB] T4 credit forfeit");
        doReset();
        input_quantums = {8'd0, 8'd0, 8'd0, 8'd20};
        applyStimulus(4'b0001, 1'b0);
        checkOutput("t4_c0_idle", 4'b0000, 1'b0, 2'd0);
        stepCheck("t4_c1_select", 4'b0000, 1'b1, 2'd0);
        stepCheck("t4_c2_gnt", 4'b0001, 1'b1, 2'd0);
        tick();
        applyStimulus(4'b0000, 1'b0);
        checkOutput("t4_c3_empty_no_gnt", 4'b0000, 1'b1, 2'd0);
        stepCheck("t4_c4_select_ptr1", 4'b0000, 1'b1, 2'd1);
        tick();
        input_quantums = '0;
        applyStimulus(4'b0001, 1'b0);
        checkOutput("t4_c5_idle", 4'b0000, 1'b0, 2'd1);
        stepCheck("t4_c6_p1", 4'b0000, 1'b1, 2'd1);
        stepCheck("t4_c7_p2", 4'b0000, 1'b1, 2'd2);
        stepCheck("t4_c8_p3", 4'b0000, 1'b1, 2'd3);
        stepCheck("t4_c9_p0", 4'b0000, 1'b1, 2'd0);
        stepCheck("t4_c10_no_credit", 4'b0000, 1'b1, 2'd0);
        stepCheck("t4_c11_p1", 4'b0000, 1'b1, 2'd1);

        // T5: backpressure freezes SERVE. Then blk rises in the same cycle
        // that reqs[ptr] falls: the freeze wins and the exit waits for blk
        // to drop.
        $display("[TB] T5 backpressure");
        doReset();
        input_quantums = {8'd0, 8'd0, 8'd0, 8'd16};
        applyStimulus(4'b0001, 1'b0);
        checkOutput("t5_c0_idle", 4'b0000, 1'b0, 2'd0);
        stepCheck("t5_c1_select", 4'b0000, 1'b1, 2'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            applyStimulus(4'b0001, 1'b1);
            checkOutput("t5_blocked", 4'b0000, 1'b1, 2'd0);
        end
        tick();
        applyStimulus(4'b0001, 1'b0);
        checkOutput("t5_gnt_after_blk", 4'b0001, 1'b1, 2'd0);
        stepCheck("t5_gnt2", 4'b0001, 1'b1, 2'd0);
        tick();
        applyStimulus(4'b0000, 1'b1);
        checkOutput("t5_blk_and_drop", 4'b0000, 1'b1, 2'd0);
        stepCheck("t5_still_frozen", 4'b0000, 1'b1, 2'd0);
        tick();
        applyStimulus(4'b0000, 1'b0);
        checkOutput("t5_exit_serve", 4'b0000, 1'b1, 2'd0);
        stepCheck("t5_select_ptr1", 4'b0000, 1'b1, 2'd1);
        stepCheck("t5_idle", 4'b0000, 1'b0, 2'd1);

        // T6a: all four requesters backlogged with quantums 8/16/24/32.
        // Ten full rounds must split 100 grants as 10/20/30/40.
        $display("[TB] T6 fairness");
        doReset();
        input_quantums = {8'd32, 8'd24, 8'd16, 8'd8};
        applyStimulus(4'b1111, 1'b0);
        total = 0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int c = 0; c < 1000 && total < 100; c++) begin
            #1;
            for (int i = 0; i < 4; i++) begin
                if (gnt[i]) begin
                    cnt[i]++;
                    total++;
                end
            end
            tick();
        end
        checks++;
        assert (total == 100)
        else begin
            errors++;
            $error("[TB] FAIL t6_total_grants: observed %0d, expected 100 within 1000 cycles", total);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            assert ((cnt[i] >= 10 * (i + 1) - 1) && (cnt[i] <= 10 * (i + 1) + 1))
            else begin
                errors++;
                $error("[TB] FAIL t6_share_r%0d: observed %0d grants, expected %0d +/- 1",
                       i, cnt[i], 10 * (i + 1));
            end
        end

        // T6b: random soak. Grants must stay at most one-hot and must never
        // pop an empty FIFO.
        for (int c = 0; c < 300; c++) begin
            applyStimulus(4'($urandom), ($urandom_range(0, 3) == 0));
            #1;
            checks++;
            assert ($onehot0(gnt) && ((gnt & ~reqs) == 4'b0000))
            else begin
                errors++;
                $error("[TB] FAIL t6_soak_cycle%0d: observed gnt=%b reqs=%b, expected one-hot-or-zero subset of reqs",
                       c, gnt, reqs);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
